// File: rtl/store_unit_pkg.sv
// Shared store-side types: funct3 encodings, FSM states, write-beat record
// and the per-size byte-enable pattern used by the aligner.
package store_unit_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } store_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_beat_t;

  // All-zero pattern doubles as the illegal-funct3 marker.
  function automatic logic [3:0] store_be_base(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   return 4'b0001;
      F3_SH:   return 4'b0011;
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store aligner: shifts SB/SH/SW data and enables into an
// 8-byte window spanning the addressed word and the next one.
module store_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output logic [63:0] wide_data,
  output logic [7:0]  wide_be,
  output logic        needs_hi,
  output logic        illegal
);

  logic [3:0]  be_base;
  logic [31:0] data_masked;

  always_comb begin
    be_base     = store_be_base(funct3);
    // Unused upper bytes of rs2 must not leak into the high beat.
    data_masked = data & {{8{be_base[3]}}, {8{be_base[2]}},
                          {8{be_base[1]}}, {8{be_base[0]}}};
    illegal     = (be_base == 4'b0000);
    wide_data   = {32'd0, data_masked} << {off, 3'b000};
    wide_be     = {4'd0, be_base} << off;
    needs_hi    = |wide_be[7:4];
  end

endmodule

// File: rtl/store_unit.sv
// Store write port: latches one request, emits one or two registered word beats.
// Low beat one cycle after accept; holds each beat until mem_ready, no accept while busy.
module store_unit
  import store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_funct3,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        store_done,
  output logic        split,
  output logic        err
);

  store_state_t state, state_nxt;
  store_beat_t  beat, beat_nxt;
  store_beat_t  hi_beat, hi_beat_nxt;
  logic         mem_valid_nxt, split_nxt, done_nxt, err_nxt;

  logic [63:0]  wide_data;
  logic [7:0]   wide_be;
  logic         needs_hi, illegal;
  logic         accept;
  logic [31:0]  word_addr;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign word_addr = {req_addr[31:2], 2'b00};

  store_align u_align (
    .off       (req_addr[1:0]),
    .data      (req_data),
    .funct3    (req_funct3),
    .wide_data (wide_data),
    .wide_be   (wide_be),
    .needs_hi  (needs_hi),
    .illegal   (illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !illegal) state_nxt = LO;
      LO:      if (mem_ready) state_nxt = split ? HI : IDLE;
      HI:      if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; the high beat is captured at
  // accept so the request inputs are free to change afterwards.
  always_comb begin
    beat_nxt      = beat;
    hi_beat_nxt   = hi_beat;
    mem_valid_nxt = mem_valid;
    split_nxt     = split;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_nxt = 1'b1;
          end else begin
            beat_nxt      = '{addr: word_addr, wdata: wide_data[31:0], be: wide_be[3:0]};
            hi_beat_nxt   = '{addr: word_addr + 32'd4, wdata: wide_data[63:32], be: wide_be[7:4]};
            mem_valid_nxt = 1'b1;
            split_nxt     = needs_hi;
          end
        end
      end
      LO: begin
        if (mem_ready) begin
          if (split) begin
            beat_nxt = hi_beat;
          end else begin
            mem_valid_nxt = 1'b0;
            split_nxt     = 1'b0;
            done_nxt      = 1'b1;
          end
        end
      end
      HI: begin
        if (mem_ready) begin
          mem_valid_nxt = 1'b0;
          split_nxt     = 1'b0;
          done_nxt      = 1'b1;
        end
      end
      default: begin
        mem_valid_nxt = 1'b0;
        split_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat       <= '0;
      hi_beat    <= '0;
      mem_valid  <= 1'b0;
      split      <= 1'b0;
      store_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      beat       <= beat_nxt;
      hi_beat    <= hi_beat_nxt;
      mem_valid  <= mem_valid_nxt;
      split      <= split_nxt;
      store_done <= done_nxt;
      err        <= err_nxt;
    end
  end

  assign mem_addr  = beat.addr;
  assign mem_wdata = beat.wdata;
  assign mem_be    = beat.be;

endmodule
